// File: rtl/led_spi_pkg.sv
// Shared constants and types for the LED SPI receiver.
// Frame layout: [31:30] reserved, [29:24] pixel address, [23:0] RGB.
package led_spi_pkg;
   localparam int ADDR_W_DEF = 6;
   localparam int DATA_W_DEF = 24;
   localparam int FRAME_BITS = 32;
   localparam int ADDR_LSB   = 24;
   localparam int RGB_LSB    = 0;
   localparam int CNT_W      = 6;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
endpackage

// File: rtl/spi_in_sync.sv
// Multi-flop synchroniser for one asynchronous SPI input.
module spi_in_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);
   logic [STAGES-1:0] ff_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ff_q <= {STAGES{RST_VAL}};
      else     ff_q <= {ff_q[STAGES-2:0], d_i};
   end

   assign q_o = ff_q[STAGES-1];
endmodule

// File: rtl/led_spi_slave.sv
// SPI mode-0 receiver: deserialises 32-bit address/RGB frames into a
// 2^ADDR_W x DATA_W frame buffer with a registered scan-side read port.
module led_spi_slave
   import led_spi_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk,
   input  logic              mosi,
   input  logic              cs,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              wr_valid,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              frame_err,
   output logic              busy
);
   // Reserved bits simply fall off the top of the shift register.
   localparam int SH_W = ADDR_LSB + ADDR_W;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0] CNT_LONG = CNT_W'(FRAME_BITS + 1);

   logic sclk_s, mosi_s, cs_s;
   logic sclk_dq, cs_dq;
   logic [SYNC_STAGES:0] flush_q;
   logic armed, sclk_rise, cs_rise, cs_fall;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [SH_W-1:0]   shift_q, shift_d;
   logic              commit_q, commit_d;
   logic              err_d;

   logic [DATA_W-1:0] mem_q [2**ADDR_W];
   logic [DATA_W-1:0] rd_data_q, wr_data_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic              wr_valid_q, frame_err_q;

   spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst(rst), .d_i(sclk), .q_o(sclk_s));
   spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .rst(rst), .d_i(mosi), .q_o(mosi_s));
   spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .clk(clk), .rst(rst), .d_i(cs), .q_o(cs_s));

   // The cs synchroniser comes out of reset reading "high"; a frame in flight
   // would look like a fresh cs fall until the sync chain has flushed.
   assign armed     = flush_q[SYNC_STAGES];
   assign sclk_rise = sclk_s & ~sclk_dq;
   assign cs_rise   = cs_s & ~cs_dq;
   assign cs_fall   = ~cs_s & cs_dq;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_dq  <= 1'b0;
         cs_dq    <= 1'b1;
         flush_q  <= '0;
         state_q  <= IDLE;
         cnt_q    <= '0;
         shift_q  <= '0;
         commit_q <= 1'b0;
      end else begin
         sclk_dq  <= sclk_s;
         cs_dq    <= cs_s;
         flush_q  <= {flush_q[SYNC_STAGES-1:0], 1'b1};
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shift_q  <= shift_d;
         commit_q <= commit_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shift_d  = shift_q;
      commit_d = 1'b0;
      err_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (armed && cs_fall) state_d = SHIFT;
         end
         SHIFT: begin
            if (sclk_rise) begin
               shift_d = {shift_q[SH_W-2:0], mosi_s};
               cnt_d   = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  state_d  = DONE;
                  commit_d = 1'b1;
               end
            end
         end
         DONE: begin
            if (sclk_rise && cnt_q != CNT_LONG) cnt_d = cnt_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
      if (cs_rise) begin
         err_d    = (state_q != IDLE) && (cnt_q != CNT_FULL);
         state_d  = IDLE;
         cnt_d    = '0;
         shift_d  = '0;
         commit_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (commit_q) mem_q[shift_q[ADDR_LSB +: ADDR_W]] <= shift_q[RGB_LSB +: DATA_W];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_q   <= '0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         wr_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         rd_data_q   <= mem_q[rd_addr];
         wr_valid_q  <= commit_q;
         frame_err_q <= err_d;
         if (commit_q) begin
            wr_addr_q <= shift_q[ADDR_LSB +: ADDR_W];
            wr_data_q <= shift_q[RGB_LSB +: DATA_W];
         end
      end
   end

   assign rd_data   = rd_data_q;
   assign wr_valid  = wr_valid_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign frame_err = frame_err_q;
   assign busy      = ~cs_s;
endmodule
